// File: rtl/mem_stage_if.sv
// mem_stage_if: the execute-side input, data-memory port and write-back output of the memory stage.
// Port summary: ex_* comes from execute; data_* is the req/gnt/rvalid memory port; wb_* goes to write-back.
// Modports: slave = the memory stage itself, master = the surrounding pipeline and memory.
interface mem_stage_if #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_mem_op;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_wreg;
  logic [REG_AW-1:0] ex_waddr;

  logic              data_req;
  logic              data_we;
  logic [3:0]        data_be;
  logic [DATA_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic              wb_wreg;
  logic [REG_AW-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_exc;

  modport slave (
    input  ex_valid, ex_mem_op, ex_alu_result, ex_store_data, ex_wreg, ex_waddr,
    output ex_ready,
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    output wb_valid, wb_wreg, wb_waddr, wb_wdata, wb_exc,
    input  wb_ready
  );

  modport master (
    output ex_valid, ex_mem_op, ex_alu_result, ex_store_data, ex_wreg, ex_waddr,
    input  ex_ready,
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    input  wb_valid, wb_wreg, wb_waddr, wb_wdata, wb_exc,
    output wb_ready
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; LB/LBU/LH/LHU/LW/SB/SH/SW over req/gnt/rvalid, misalignment flagging.
// Latency: non-memory/misaligned ops 1 cycle (1/cycle throughput); aligned access 3 cycles min (gnt t+1, rvalid t+2).
// Backpressure: ex_ready only in IDLE with a free wb slot; wb_* held until wb_ready; a late result parks in HOLD.
// Ports: clk, rst (sync, active-low), bus (mem_stage_if.slave).
module mem_stage #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LBU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LHU = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] addr_q;
  logic              wreg_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] hold_q;

  logic              data_req_q, data_we_q;
  logic [3:0]        data_be_q;
  logic [DATA_W-1:0] data_addr_q, data_wdata_q;
  logic              wb_valid_q, wb_wreg_q, wb_exc_q;
  logic [REG_AW-1:0] wb_waddr_q;
  logic [DATA_W-1:0] wb_wdata_q;

  assign bus.data_req   = data_req_q;
  assign bus.data_we    = data_we_q;
  assign bus.data_be    = data_be_q;
  assign bus.data_addr  = data_addr_q;
  assign bus.data_wdata = data_wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_wreg    = wb_wreg_q;
  assign bus.wb_waddr   = wb_waddr_q;
  assign bus.wb_wdata   = wb_wdata_q;
  assign bus.wb_exc     = wb_exc_q;

  logic slot_free, ex_ready, ex_fire;
  assign slot_free    = !wb_valid_q || bus.wb_ready;
  assign ex_ready     = (state_q == IDLE) && slot_free;
  assign bus.ex_ready = ex_ready;
  assign ex_fire      = bus.ex_valid && ex_ready;

  // Decode of the incoming op; unknown codes fall through as "no memory access".
  logic ex_load, ex_store, ex_half, ex_word, ex_misal;
  always_comb begin
    ex_load  = 1'b0;
    ex_store = 1'b0;
    ex_half  = 1'b0;
    ex_word  = 1'b0;
    case (bus.ex_mem_op)
      OP_LB, OP_LBU: ex_load = 1'b1;
      OP_LH, OP_LHU: begin ex_load = 1'b1; ex_half = 1'b1; end
      OP_LW:         begin ex_load = 1'b1; ex_word = 1'b1; end
      OP_SB:         ex_store = 1'b1;
      OP_SH:         begin ex_store = 1'b1; ex_half = 1'b1; end
      OP_SW:         begin ex_store = 1'b1; ex_word = 1'b1; end
      default:       ;
    endcase
    ex_misal = (ex_half && bus.ex_alu_result[0]) ||
               (ex_word && (bus.ex_alu_result[1:0] != 2'b00));
  end

  // Byte enables and lane-replicated write data for the request about to be issued.
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (ex_store) begin
      if (ex_word) begin
        wdata_d = bus.ex_store_data;
      end else if (ex_half) begin
        be_d    = bus.ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.ex_store_data[15:0]}};
      end else begin
        be_d    = 4'b0001 << bus.ex_alu_result[1:0];
        wdata_d = {4{bus.ex_store_data[7:0]}};
      end
    end
  end

  // Result of the outstanding access once its response arrives.
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [DATA_W-1:0] result_d;
  logic              res_wreg_d;
  always_comb begin
    rbyte = bus.data_rdata[8*addr_q[1:0] +: 8];
    rhalf = bus.data_rdata[16*addr_q[1] +: 16];
    case (op_q)
      OP_LB:   result_d = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  result_d = {24'd0, rbyte};
      OP_LH:   result_d = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  result_d = {16'd0, rhalf};
      OP_LW:   result_d = bus.data_rdata;
      default: result_d = addr_q;  // stores report their address; wreg is forced low anyway
    endcase
    // Only loads are captured with op_q[3]=0, so that bit alone separates loads from stores.
    res_wreg_d = wreg_q && !op_q[3];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wreg_q       <= 1'b0;
      waddr_q      <= '0;
      hold_q       <= '0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_wreg_q    <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= '0;
      wb_exc_q     <= 1'b0;
    end else begin
      // Consumed result retires; a load below in the same cycle overrides this.
      if (wb_valid_q && bus.wb_ready) wb_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ex_fire) begin
            if (!ex_load && !ex_store) begin
              wb_valid_q <= 1'b1;
              wb_wdata_q <= bus.ex_alu_result;
              wb_wreg_q  <= bus.ex_wreg;
              wb_waddr_q <= bus.ex_waddr;
              wb_exc_q   <= 1'b0;
            end else if (ex_misal) begin
              wb_valid_q <= 1'b1;
              wb_wdata_q <= bus.ex_alu_result;
              wb_wreg_q  <= 1'b0;
              wb_waddr_q <= bus.ex_waddr;
              wb_exc_q   <= 1'b1;
            end else begin
              op_q         <= bus.ex_mem_op;
              addr_q       <= bus.ex_alu_result;
              wreg_q       <= bus.ex_wreg;
              waddr_q      <= bus.ex_waddr;
              data_req_q   <= 1'b1;
              data_we_q    <= ex_store;
              data_be_q    <= be_d;
              data_addr_q  <= {bus.ex_alu_result[DATA_W-1:2], 2'b00};
              data_wdata_q <= wdata_d;
              state_q      <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.data_gnt) begin
            data_req_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.data_rvalid) begin
            if (slot_free) begin
              wb_valid_q <= 1'b1;
              wb_wdata_q <= result_d;
              wb_wreg_q  <= res_wreg_d;
              wb_waddr_q <= waddr_q;
              wb_exc_q   <= 1'b0;
              state_q    <= IDLE;
            end else begin
              hold_q  <= result_d;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            wb_valid_q <= 1'b1;
            wb_wdata_q <= hold_q;
            wb_wreg_q  <= res_wreg_d;
            wb_waddr_q <= waddr_q;
            wb_exc_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage, upstream of write-back.
- Takes the ALU result and store data from execute and performs LB/LBU/LH/LHU/LW/SB/SH/SW through a req/gnt/rvalid data-memory port.
- Aligns load data and sign- or zero-extends it.
- Flags misaligned accesses and presents a registered result to write-back under a valid/ready handshake.

Parameters:
- REG_AW, 5, register-file address width.
- DATA_W, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- ex_valid  in  1  execute-stage output valid
- ex_ready  out  1  stage can accept
- ex_mem_op  in  4  0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1010 SH, 1011 SW; any other code is treated as none
- ex_alu_result  in  32  ALU result, which is also the effective address
- ex_store_data  in  32  rt value for stores
- ex_wreg  in  1  instruction writes the register file
- ex_waddr  in  REG_AW  destination register
- data_req  out  1  memory request
- data_we  out  1  1 = store
- data_be  out  4  byte enables
- data_addr  out  32  word address, {addr[31:2],2'b00}
- data_wdata  out  32  lane-replicated store data
- data_gnt  in  1  request accepted
- data_rvalid  in  1  response (load data or store ack)
- data_rdata  in  32  load word
- wb_valid  out  1  result valid
- wb_ready  in  1  write-back accepts
- wb_wreg  out  1  write enable
- wb_waddr  out  REG_AW  destination
- wb_wdata  out  32  result
- wb_exc  out  1  address-error flag

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; data_req, wb_valid, wb_wreg, wb_exc = 0; wb_waddr, wb_wdata, data_* = 0.
- slot_free = !wb_valid || wb_ready.
- ex_ready = (state==IDLE) && slot_free. An instruction is accepted on ex_valid && ex_ready.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE, accepting a non-memory op:
  - wb_valid=1 next cycle; wb_wdata=ex_alu_result; wb_wreg=ex_wreg; wb_exc=0.
  - Latency 1; stays in IDLE, so back-to-back throughput is 1/cycle.
- IDLE, accepting a misaligned op:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No memory access. Next cycle: wb_valid=1, wb_exc=1, wb_wreg=0, wb_wdata=address.
- IDLE, accepting an aligned memory op: capture op, address, store data and waddr; go to REQ.
- REQ:
  - data_req=1, with data_we/be/addr/wdata held stable until data_gnt.
  - On data_gnt: data_req drops the next cycle; go to WAIT.
- WAIT:
  - data_rvalid is honoured no earlier than the cycle after gnt.
  - On rvalid: if slot_free, load wb_* and go to IDLE; otherwise buffer the result and go to HOLD.
- HOLD: when slot_free, load wb_* from the buffer and go to IDLE.
- Stray data_rvalid in IDLE or REQ is ignored.
- Store encoding:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{half}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111 and data_we=0.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Completion: stores complete with wb_wreg=0; loads use the captured ex_wreg.
- wb_valid is held with stable contents until wb_ready. It drops the cycle after the handshake unless a new result is loaded in that same cycle.
- Timing for an aligned load accepted at cycle t:
  - data_req=1 at t+1.
  - With gnt at t+1 and rvalid at t+2, wb_valid=1 at t+3.
  - ex_ready returns at t+3.
- Reset mid-transaction: all state is cleared within one cycle and data_req drops. The memory model is reset alongside.

Test Plan:
- Non-mem stream: 3 back-to-back ops with ALU results 1, 2, 3 and wb_ready=1 -> wb_wdata 1, 2, 3 on consecutive cycles; ex_ready constantly 1; data_req never asserted.
- LB sign and LBU zero extension: addr 0x1003, rdata 0x80AA55CC -> LB gives 0xFFFFFF80 and LBU gives 0x00000080; data_addr=0x1000; wb_valid at t+3.
- SH at addr 0x2002, store_data 0x1234BEEF -> data_be=4'b1100, data_wdata=0xBEEFBEEF, data_we=1; completion has wb_wreg=0.
- Misaligned LW at 0x3001 -> no data_req; next cycle wb_exc=1, wb_wreg=0, wb_wdata=0x3001.
- Backpressure and gnt delay:
  - LW with gnt delayed 3 cycles -> data_req stays 1 with stable fields.
  - With wb_ready=0 at rvalid -> FSM enters HOLD and ex_ready=0.
  - Releasing wb_ready -> correct data is delivered exactly once.
- Reset mid-REQ: rst=0 while data_req=1 -> next cycle data_req=0, wb_valid=0, ex_ready=1 after release.
